// File: rtl/exibidor_sequencia_leds.sv
// Plays a stored nibble sequence on the LEDs (addresses 0..tamanho), each element
// lit for T_ON cycles then dark for T_OFF cycles, and pulses pronto when done.
module exibidor_sequencia_leds #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] tamanho,
    input  logic [DATA_W-1:0] dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    // state   | meaning
    // OCIOSO  | idle, waiting for iniciar
    // BUSCA   | address stable, memory read in flight
    // CAPTURA | read data registered into the LED holding register
    // MOSTRA  | element lit for T_ON cycles
    // APAGA   | LEDs dark for T_OFF cycles, then next address or FIM
    // FIM     | one-cycle pronto pulse
    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        BUSCA   = 4'd1,
        CAPTURA = 4'd2,
        MOSTRA  = 4'd3,
        APAGA   = 4'd4,
        FIM     = 4'd5
    } estado_t;

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

    estado_t           estado;
    logic [TW-1:0]     timer;
    logic [ADDR_W-1:0] ultimo;

    // leds doubles as the holding register: loaded in CAPTURA, cleared leaving MOSTRA
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado   <= OCIOSO;
            endereco <= '0;
            leds     <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            timer    <= '0;
            ultimo   <= '0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        ultimo   <= tamanho;
                        endereco <= '0;
                        ocupado  <= 1'b1;
                        estado   <= BUSCA;
                    end
                end
                BUSCA: begin
                    estado <= CAPTURA;
                end
                CAPTURA: begin
                    leds   <= dado_memoria;
                    timer  <= '0;
                    estado <= MOSTRA;
                end
                MOSTRA: begin
                    if (timer == ON_LAST) begin
                        timer  <= '0;
                        leds   <= '0;
                        estado <= APAGA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                APAGA: begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        if (endereco == ultimo) begin
                            pronto <= 1'b1;
                            estado <= FIM;
                        end else begin
                            endereco <= endereco + 1'b1;
                            estado   <= BUSCA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FIM: begin
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    leds    <= '0;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_exibidor_sequencia_leds.sv
// Bench for exibidor_sequencia_leds: directed scenarios plus random traffic,
// checked every cycle against a timeline model of the playback.
module tb_exibidor_sequencia_leds;

    localparam int T_ON  = 3;
    localparam int T_OFF = 2;
    localparam int PER   = 2 + T_ON + T_OFF;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] tamanho = '0;
    logic [3:0] dado_memoria = '0;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];

    int n_cmp = 0;
    int n_err = 0;
    int ciclo = 0;

    // playback model: time since start edge, element count, idle address
    int m_busy = 0;
    int m_t = 0;
    int m_n = 0;
    int m_addr = 0;
    int pronto_exp_cnt = 0;
    int pronto_obs_cnt = 0;

    exibidor_sequencia_leds #(
        .ADDR_W(4), .DATA_W(4), .T_ON(T_ON), .T_OFF(T_OFF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .tamanho(tamanho),
        .dado_memoria(dado_memoria),
        .endereco(endereco),
        .leds(leds),
        .ocupado(ocupado),
        .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) dado_memoria <= mem[endereco];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, ciclo, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            m_busy = 0;
            m_addr = 0;
        end else if (m_busy != 0) begin
            m_t++;
            if (m_t > m_n * PER) begin
                m_busy = 0;
                m_addr = m_n - 1;
            end
        end else if (iniciar) begin
            m_busy = 1;
            m_t = 0;
            m_n = int'(tamanho) + 1;
        end
    endtask

    task automatic check_outputs();
        int e, o, x_leds, x_end, x_ocu, x_pro, x_est;
        if (m_busy == 0) begin
            x_leds = 0; x_end = m_addr; x_ocu = 0; x_pro = 0; x_est = 0;
        end else if (m_t < m_n * PER) begin
            e = m_t / PER;
            o = m_t % PER;
            x_end = e; x_ocu = 1; x_pro = 0;
            x_leds = (o >= 2 && o < 2 + T_ON) ? int'(mem[e]) : 0;
            if (o == 0)             x_est = 1;
            else if (o == 1)        x_est = 2;
            else if (o < 2 + T_ON)  x_est = 3;
            else                    x_est = 4;
        end else begin
            x_leds = 0; x_end = m_n - 1; x_ocu = 1; x_pro = 1; x_est = 5;
        end
        if (x_pro == 1) pronto_exp_cnt++;
        if (pronto === 1'b1) pronto_obs_cnt++;
        chk("leds", 32'(leds), 32'(x_leds));
        chk("endereco", 32'(endereco), 32'(x_end));
        chk("ocupado", 32'(ocupado), 32'(x_ocu));
        chk("pronto", 32'(pronto), 32'(x_pro));
        chk("db_estado", 32'(db_estado), 32'(x_est));
    endtask

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clock);
            model_edge();
            @(negedge clock);
            ciclo++;
            check_outputs();
        end
    endtask

    task automatic start(input int tam);
        tamanho = 4'(tam);
        iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
        mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8; mem[5] = 4'd0;

        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(2);

        start(0);
        cyc(12);

        start(3);
        cyc(32);

        start(3);
        cyc(8);
        iniciar = 1'b1; tamanho = 4'd1;
        cyc(2);
        iniciar = 1'b0;
        cyc(28);

        start(3);
        cyc(16);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(3);
        start(2);
        cyc(25);

        start(15);
        cyc(16 * PER + 4);

        start(5);
        cyc(10);
        reset = 1'b0; iniciar = 1'b1;
        cyc(1);
        reset = 1'b1; iniciar = 1'b0;
        cyc(3);

        iniciar = 1'b1; tamanho = 4'd0;
        cyc(30);
        iniciar = 1'b0;
        cyc(3);

        for (int i = 0; i < 2000; i++) begin
            iniciar = ($urandom_range(0, 19) == 0);
            tamanho = 4'($urandom_range(0, 15));
            reset   = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        reset = 1'b1; iniciar = 1'b0;
        cyc(16 * PER + 4);

        chk("pronto_count", 32'(pronto_obs_cnt), 32'(pronto_exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exibidor_sequencia_leds.md
Name: exibidor_sequencia_leds

Overview:
- Playback side of the memory game. Sequence memory feeds the LEDs; the player then answers on `botoes`.
- On `iniciar`, reads sequence memory from address 0 through a latched last address.
- Lights each stored nibble on `leds` for T_ON cycles, then blanks for T_OFF cycles.
- Pulses `pronto` when the sequence is finished, so the game controller can enter the player-response phase.

Parameters:
- ADDR_W, 4, width of the memory address and of `tamanho`.
- DATA_W, 4, width of a memory word and of `leds`.
- T_ON, 1000, cycles each element is lit. Must be >= 1.
- T_OFF, 500, cycles LEDs are dark between elements. Must be >= 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset, sampled on the clock edge).
- iniciar  in  1  start request; sampled only in OCIOSO.
- tamanho  in  ADDR_W  last address to display (inclusive); latched when a start is accepted.
- dado_memoria  in  DATA_W  read data from sequence memory; one-cycle synchronous read latency tolerated.
- endereco  out  ADDR_W  read address to sequence memory (registered).
- leds  out  DATA_W  LED drive; 0 when not in MOSTRA.
- ocupado  out  1  high in every state except OCIOSO.
- pronto  out  1  one-cycle pulse in FIM.
- db_estado  out  4  current state code, for hexa7seg debug display.

Behaviour:

Reset (reset=0 at an edge):
- State returns to OCIOSO.
- endereco=0, leds=0, ocupado=0, pronto=0, timer=0, latched tamanho=0.
- Applies from any state, including mid-display; LEDs are dark the following cycle.

States and codes:
- OCIOSO (0): idle.
  - If iniciar=1: latch tamanho, set endereco=0 → BUSCA.
  - Otherwise stay.
- BUSCA (1): endereco is stable. Exactly one cycle, covering memory latency → CAPTURA.
- CAPTURA (2): exactly one cycle.
  - Register dado_memoria into the LED holding register.
  - Clear timer → MOSTRA.
- MOSTRA (3): leds = holding register; timer counts.
  - When timer = T_ON-1: clear timer → APAGA.
- APAGA (4): leds = 0; timer counts.
  - When timer = T_OFF-1:
    - if endereco == latched tamanho → FIM;
    - else endereco+1 → BUSCA.
- FIM (5): pronto=1 for exactly this one cycle → OCIOSO.

Timing and counting rules:
- Cycles per element: 2 + T_ON + T_OFF.
- Total for N = tamanho+1 elements: N·(2+T_ON+T_OFF) + 1 (FIM), counted from the first BUSCA cycle.
- Timer width is clog2(max(T_ON,T_OFF)) bits.
- Timer and address comparisons are equality-based; endereco never wraps.
  - tamanho = 2^ADDR_W − 1 shows all addresses and stops there.
  - tamanho = 0 shows a single element.

Boundary conditions:
- iniciar while ocupado=1: ignored. Changes to tamanho during playback: ignored.
- iniciar held high across FIM: a new playback starts from the OCIOSO cycle after FIM, and pronto is still seen.
- An element value of 0 displays as dark LEDs for T_ON; the timing is unchanged.
- Simultaneous reset=0 and iniciar=1: reset wins.

Test Plan (T_ON=3, T_OFF=2, memory preloaded 0:1, 1:2, 2:4, 3:8, synchronous ROM):
- Reset check: reset=0 for 2 cycles → leds=0, endereco=0, ocupado=0, pronto=0, db_estado=0.
- tamanho=0 with 1-cycle iniciar:
  - leds=1 for exactly 3 cycles, starting 3 cycles after the iniciar edge, then 0 for 2 cycles;
  - pronto pulses once, 8 cycles after the first BUSCA;
  - ocupado falls the cycle after pronto.
- tamanho=3:
  - leds sequence 1,2,4,8, each lasting 3 cycles, separated by 2-cycle gaps of 0;
  - endereco steps 0→3 and never reaches 4;
  - pronto is a single pulse after 4·7+1 = 29 cycles.
- iniciar pulsed again, with tamanho changed to 1, during the second element of a tamanho=3 run → run still displays all 4 elements; no restart.
- reset=0 asserted during MOSTRA of element 2 → next cycle leds=0, db_estado=0, no pronto; a fresh iniciar restarts from address 0.
- iniciar held high continuously, tamanho=0 → back-to-back playbacks, each one 7+1 cycles, with one OCIOSO cycle between them; pronto pulses once per playback.
